// File: rtl/control_pkg.sv
// Shared definitions for the instruction-sequencing control unit:
// state encoding, opcode map, ALU select codes and the control word layout.
package control_pkg;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS0 = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;

    typedef struct packed {
        logic       pc_clr;
        logic       ir_ld;
        logic       pc_up;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rf_w_addr;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic       rf_w_en;
        logic [2:0] alu_s0;
    } ctrl_t;

    // Unassigned opcodes fall through to the NoOp path.
    function automatic state_t decode_target(input logic [3:0] opcode);
        case (opcode)
            OP_NOOP:  return ST_NOOP;
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOAD_A;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
            default:  return ST_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control FSM: fetch / decode / execute sequencing for a small
// load-store datapath. Outputs depend only on the current state and IR fields.
module control_unit
    import control_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        IR_Ld,
    output logic        PC_Up,
    output logic [7:0]  D_Addr,
    output logic        D_Wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic        RF_W_en,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  OutState
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its pre-edge inputs; the async reset drops straight to Init.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb assigns a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = decode_target(IR[15:12]);
            ST_NOOP:   state_d = ST_FETCH;
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_FETCH;
            ST_STORE:  state_d = ST_FETCH;
            ST_ADD:    state_d = ST_FETCH;
            ST_SUB:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // IR feeds only address fields, never the PC / IR strobes.
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_INIT: begin
                ctrl.pc_clr = 1'b1;
            end
            ST_FETCH: begin
                ctrl.ir_ld = 1'b1;
                ctrl.pc_up = 1'b1;
            end
            ST_STORE: begin
                ctrl.d_addr     = IR[7:0];
                ctrl.rf_ra_addr = IR[11:8];
                ctrl.d_wr       = 1'b1;
            end
            ST_LOAD_A: begin
                ctrl.d_addr = IR[11:4];
                ctrl.rf_s   = 1'b1;
            end
            ST_LOAD_B: begin
                ctrl.d_addr    = IR[11:4];
                ctrl.rf_s      = 1'b1;
                ctrl.rf_w_addr = IR[3:0];
                ctrl.rf_w_en   = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                ctrl.rf_ra_addr = IR[11:8];
                ctrl.rf_rb_addr = IR[7:4];
                ctrl.rf_w_addr  = IR[3:0];
                ctrl.alu_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
                ctrl.rf_w_en    = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign PC_clr     = ctrl.pc_clr;
    assign IR_Ld      = ctrl.ir_ld;
    assign PC_Up      = ctrl.pc_up;
    assign D_Addr     = ctrl.d_addr;
    assign D_Wr       = ctrl.d_wr;
    assign RF_s       = ctrl.rf_s;
    assign RF_W_addr  = ctrl.rf_w_addr;
    assign RF_Ra_addr = ctrl.rf_ra_addr;
    assign RF_Rb_addr = ctrl.rf_rb_addr;
    assign RF_W_en    = ctrl.rf_w_en;
    assign ALU_s0     = ctrl.alu_s0;
    assign OutState   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: every step compares the full output word
// against a hand-written expectation for the state the FSM should be in.
module tb_control_unit;
    import control_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [15:0] IR;
    logic        PC_clr, IR_Ld, PC_Up, D_Wr, RF_s, RF_W_en;
    logic [7:0]  D_Addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  ALU_s0;

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR         (IR),
        .PC_clr     (PC_clr),
        .IR_Ld      (IR_Ld),
        .PC_Up      (PC_Up),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .RF_W_en    (RF_W_en),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // strb = {PC_clr, IR_Ld, PC_Up, D_Wr, RF_s, RF_W_en}
    task automatic expect_all(input string tag, input state_t st, input logic [5:0] strb,
                              input logic [2:0] alu, input logic [7:0] addr,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] w);
        logic [39:0] obs;
        logic [39:0] exp;
        obs = {7'd0, PC_clr, IR_Ld, PC_Up, D_Wr, RF_s, RF_W_en, ALU_s0, D_Addr,
               RF_Ra_addr, RF_Rb_addr, RF_W_addr, OutState};
        exp = {7'd0, strb, alu, addr, ra, rb, w, 4'(st)};
        check(tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // The two write strobes must never coincide.
    always @(negedge Clk) begin
        check("wr_exclusive", {39'd0, D_Wr & RF_W_en}, 40'd0);
    end

    initial begin
        Reset = 1'b1;
        IR    = 16'h0000;
        #3;
        expect_all("reset_init", ST_INIT, 6'b100000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("reset_held", ST_INIT, 6'b100000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        #5;
        Reset = 1'b0;
        IR    = 16'h3125;

        // ADD r5 = r1 + r2
        tick();
        expect_all("add_fetch", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("add_decode", ST_DECODE, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("add_exec", ST_ADD, 6'b000001, 3'b001, 8'h00, 4'd1, 4'd2, 4'd5);
        tick();
        expect_all("add_done", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        IR = 16'h21A7;

        // LOAD r7 <- mem[0x1A]
        tick();
        expect_all("load_decode", ST_DECODE, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("load_a", ST_LOAD_A, 6'b000010, 3'd0, 8'h1A, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("load_b", ST_LOAD_B, 6'b000011, 3'd0, 8'h1A, 4'd0, 4'd0, 4'd7);
        tick();
        expect_all("load_done", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        IR = 16'h1340;

        // STORE mem[0x40] <- r3
        tick();
        expect_all("store_decode", ST_DECODE, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("store_exec", ST_STORE, 6'b000100, 3'd0, 8'h40, 4'd3, 4'd0, 4'd0);
        tick();
        expect_all("store_done", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        IR = 16'h4321;

        // SUB r1 = r3 - r2
        tick();
        tick();
        expect_all("sub_exec", ST_SUB, 6'b000001, 3'b010, 8'h00, 4'd3, 4'd2, 4'd1);
        tick();
        expect_all("sub_done", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        IR = 16'h0ABC;

        // NOOP opcode with non-zero operand bits
        tick();
        tick();
        expect_all("noop_exec", ST_NOOP, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("noop_done", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        IR = 16'h5000;

        // HALT is absorbing
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_all($sformatf("halt_hold%0d", i), ST_HALT, 6'b000000, 3'd0, 8'h00,
                       4'd0, 4'd0, 4'd0);
        end

        // Asynchronous reset pulse between edges leaves Halt
        Reset = 1'b1;
        #1;
        expect_all("halt_reset", ST_INIT, 6'b100000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        #2;
        Reset = 1'b0;
        IR    = 16'hF000;

        // Invalid opcode follows the NoOp path
        tick();
        expect_all("inv_fetch", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("inv_decode", ST_DECODE, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("inv_noop", ST_NOOP, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("inv_done", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        IR = 16'h21A7;

        // Abort a LOAD in LoadA: no register write may follow
        tick();
        tick();
        expect_all("abort_load_a", ST_LOAD_A, 6'b000010, 3'd0, 8'h1A, 4'd0, 4'd0, 4'd0);
        #1;
        Reset = 1'b1;
        #1;
        expect_all("abort_init", ST_INIT, 6'b100000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("abort_held", ST_INIT, 6'b100000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        #3;
        Reset = 1'b0;
        tick();
        expect_all("abort_fetch", ST_FETCH, 6'b011000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);
        tick();
        expect_all("abort_decode", ST_DECODE, 6'b000000, 3'd0, 8'h00, 4'd0, 4'd0, 4'd0);

        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have the port Clk  input  1  system clock; all state changes occur on the rising edge.
REQ-002 The block SHALL have the port Reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have the port IR  input  16  instruction register contents; opcode IR[15:12].
REQ-004 The block SHALL have the ports PC_clr, IR_Ld, PC_Up  output  1 each  program counter clear, instruction register load and PC increment.
REQ-005 The block SHALL have the ports D_Addr  output  8  and D_Wr  output  1  data memory address and write enable.
REQ-006 The block SHALL have the ports RF_s  output  1  write-back mux select, where 0 selects the ALU result and 1 selects RAM read data.
REQ-007 The block SHALL have the ports RF_W_addr, RF_Ra_addr, RF_Rb_addr  output  4 each  and RF_W_en  output  1  for the register file.
REQ-008 The block SHALL have the port ALU_s0  output  3  ALU operation select (000 pass-zero, 001 add, 010 subtract).
REQ-009 The block SHALL have the port OutState  output  4  current state encoding, for display.

Function
REQ-010 Opcodes SHALL be NOOP=0000, STORE=0001, LOAD=0010, ADD=0011, SUB=0100, HALT=0101; opcodes 0110-1111 SHALL execute as NOOP.
REQ-011 Field mapping SHALL be: LOAD IR[11:4]=D_Addr, IR[3:0]=RF_W_addr; STORE IR[11:8]=RF_Ra_addr, IR[7:0]=D_Addr; ADD/SUB IR[11:8]=Ra, IR[7:4]=Rb, IR[3:0]=W.
REQ-012 States SHALL be Init, Fetch, Decode, NoOp, LoadA, LoadB, Store, Add, Sub, Halt, encoded 0-9 on OutState.
REQ-013 Init SHALL assert PC_clr and then go to Fetch.
REQ-014 Fetch SHALL assert IR_Ld and PC_Up for exactly one cycle and then go to Decode.
REQ-015 Decode SHALL drive no strobes and SHALL branch on IR[15:12] to NoOp, Store, LoadA, Add, Sub or Halt.
REQ-016 NoOp SHALL return to Fetch.
REQ-017 Store SHALL assert D_Wr=1 with D_Addr and RF_Ra_addr from IR, and SHALL then return to Fetch.
REQ-018 LoadA SHALL drive D_Addr from IR with RF_s=1 and RF_W_en=0; LoadB SHALL hold D_Addr and RF_s=1 and assert RF_W_en=1 to RF_W_addr, then return to Fetch.
REQ-019 Add and Sub SHALL drive Ra, Rb, W from IR with ALU_s0=001 or 010 respectively, RF_s=0 and RF_W_en=1, then return to Fetch.
REQ-020 Halt SHALL be absorbing: it SHALL hold all strobes low and exit only through Reset.
REQ-021 Instruction latency SHALL be 3 cycles (Fetch, Decode, one execute state), or 4 cycles for LOAD.
REQ-022 Outputs SHALL be Moore: a function of the state and IR only, with no combinational path from IR to IR_Ld, PC_Up or PC_clr.
REQ-023 In every state, all outputs not explicitly listed for that state SHALL be 0.
REQ-024 D_Wr and RF_W_en SHALL never be asserted in the same cycle.

Reset
REQ-025 Reset asserted SHALL immediately force state Init (OutState=0) and PC_clr=1, with all other outputs 0, regardless of the clock.
REQ-026 Reset asserted mid-instruction (including in LoadA, Store or Halt) SHALL abort the instruction with no write strobe issued.
REQ-027 After Reset deasserts, the first rising edge SHALL move the state to Fetch.

Structure
REQ-028 A shared package control_pkg SHALL hold the state enum, the opcode constants and the ALU_s0 codes, for reuse by the datapath and the bench.
REQ-029 The block SHALL be a single module with no sub-module: one state register process, one next-state process and one output decode.

Verification
REQ-030 The bench SHALL cover reset then release: Reset=1 -> OutState=0 and PC_clr=1; after release, OutState sequence 1,2.
REQ-031 The bench SHALL cover ADD: IR=16'h3125 -> Ra=1, Rb=2, W=5, ALU_s0=001, RF_s=0, RF_W_en=1 for exactly one cycle.
REQ-032 The bench SHALL cover LOAD: IR=16'h21A7 -> D_Addr=8'h1A for 2 cycles, RF_s=1, RF_W_en=1 only in LoadB, RF_W_addr=7.
REQ-033 The bench SHALL cover STORE: IR=16'h1340 -> Ra=3, D_Addr=8'h40, D_Wr=1 for one cycle, RF_W_en=0.
REQ-034 The bench SHALL cover HALT then invalid: IR=16'h5000 -> OutState=9 held for 20 cycles with all strobes 0; IR=16'hF000 after reset -> NoOp path.
REQ-035 The bench SHALL cover async abort: Reset pulsed between clock edges during LoadA -> Init immediately, with RF_W_en never asserted.
